// File: rtl/outgoing_packet_tx.sv
// outgoing_packet_tx
//   Holds the 16-byte outgoing key-exchange packet and serialises it as a framed
//   byte stream: PREAMBLE, PACKET_BYTES payload bytes, optional XOR checksum.
//   The stream uses a valid/ready handshake, and every output is registered.
//   Optional feature macro: PACKET_TX_CHECKSUM_EN appends an XOR-of-payload byte.
//
//   state | meaning
//   IDLE  | waiting for a sending rising edge; buffer writable
//   PRE   | preamble byte presented on tx_data
//   PAY   | payload byte buf[cnt] presented on tx_data
//   CHK   | checksum byte presented (PACKET_TX_CHECKSUM_EN only)
//   END   | frame done; packet_sent pulses, back to IDLE next cycle

module outgoing_packet_tx #(
    parameter int         PACKET_BYTES = 16,
    parameter logic [7:0] PREAMBLE     = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] outgoing_packet_write_index,
    input  logic [7:0] outgoing_packet_write_data,
    input  logic       outgoing_packet_write_enable,
    input  logic       outgoing_packet_sending,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       packet_sent,
    output logic       write_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_END
`ifdef PACKET_TX_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(PACKET_BYTES - 1);

    state_t     state_q;
    logic [7:0] buf_q [PACKET_BYTES];
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       busy_q;
    logic       packet_sent_q;
    logic       write_dropped_q;
    logic       sending_q;
    logic [3:0] cnt_q;
`ifdef PACKET_TX_CHECKSUM_EN
    logic [7:0] xor_q;
`endif

    logic       index_ok_d;
    logic       write_d;
    logic       start_d;
    logic       accept_d;
    logic [3:0] cnt_next_d;

    assign index_ok_d = ({1'b0, outgoing_packet_write_index} < 5'(PACKET_BYTES));
    assign write_d    = outgoing_packet_write_enable && !busy_q && index_ok_d;
    assign start_d    = outgoing_packet_sending && !sending_q && (state_q == S_IDLE);
    assign accept_d   = tx_valid_q && tx_ready;
    assign cnt_next_d = cnt_q + 4'd1;

    // Packet buffer: writable only while no frame is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PACKET_BYTES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (write_d) begin
            buf_q[outgoing_packet_write_index] <= outgoing_packet_write_data;
        end
    end

    // Flag writes that were rejected because a frame was being sent.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_dropped_q <= 1'b0;
        end else begin
            write_dropped_q <= outgoing_packet_write_enable && busy_q;
        end
    end

    // Framing FSM; all stream outputs change only on an accept or a start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            packet_sent_q <= 1'b0;
            sending_q     <= 1'b0;
            cnt_q         <= '0;
`ifdef PACKET_TX_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            sending_q     <= outgoing_packet_sending;
            packet_sent_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q    <= S_PRE;
                        tx_data_q  <= PREAMBLE;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (accept_d) begin
                        state_q   <= S_PAY;
                        cnt_q     <= '0;
                        tx_data_q <= buf_q[0];
`ifdef PACKET_TX_CHECKSUM_EN
                        xor_q     <= '0;
`endif
                    end
                end
                S_PAY: begin
                    if (accept_d) begin
`ifdef PACKET_TX_CHECKSUM_EN
                        xor_q <= xor_q ^ tx_data_q;
`endif
                        if (cnt_q == LAST_IDX) begin
`ifdef PACKET_TX_CHECKSUM_EN
                            state_q   <= S_CHK;
                            tx_data_q <= xor_q ^ tx_data_q;
`else
                            state_q       <= S_END;
                            tx_data_q     <= '0;
                            tx_valid_q    <= 1'b0;
                            busy_q        <= 1'b0;
                            packet_sent_q <= 1'b1;
`endif
                        end else begin
                            cnt_q     <= cnt_next_d;
                            tx_data_q <= buf_q[cnt_next_d];
                        end
                    end
                end
`ifdef PACKET_TX_CHECKSUM_EN
                S_CHK: begin
                    if (accept_d) begin
                        state_q       <= S_END;
                        tx_data_q     <= '0;
                        tx_valid_q    <= 1'b0;
                        busy_q        <= 1'b0;
                        packet_sent_q <= 1'b1;
                    end
                end
`endif
                S_END: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign packet_sent   = packet_sent_q;
    assign write_dropped = write_dropped_q;

endmodule
